// File: rtl/fmul_72bit_result_pack_if.sv
// Result-pack bus: upstream result fields and flags in, packed result with
// status out through a 2-entry FIFO, plus sticky-flag control.
// The slave modport is the pack stage; the master modport is its environment.
interface fmul_72bit_result_pack_if;
    // Upstream side
    logic        iDATA_VALID;
    logic        oDATA_BUSY;
    logic        iDATA_SIGN;
    logic [12:0] iDATA_EXP;
    logic [60:0] iDATA_FRACT;
    logic        iDATA_EXCEPT_EXP_A0;
    logic        iDATA_EXCEPT_EXP_B0;
    logic        iDATA_EXCEPT_EXP_A1;
    logic        iDATA_EXCEPT_EXP_B1;
    logic        iDATA_EXCEPT_FRACT_A0;
    logic        iDATA_EXCEPT_FRACT_B0;
    // Consumer side
    logic        oDATA_VALID;
    logic        iDATA_BUSY;
    logic [71:0] oDATA_RESULT;
    logic        oDATA_OVERFLOW;
    logic        oDATA_UNDERFLOW;
    logic        oDATA_INVALID;
    // Sticky exception flags
    logic        iFLAG_CLEAR;
    logic [2:0]  oFLAG_STICKY;

    modport slave (
        input  iDATA_VALID,
        output oDATA_BUSY,
        input  iDATA_SIGN,
        input  iDATA_EXP,
        input  iDATA_FRACT,
        input  iDATA_EXCEPT_EXP_A0,
        input  iDATA_EXCEPT_EXP_B0,
        input  iDATA_EXCEPT_EXP_A1,
        input  iDATA_EXCEPT_EXP_B1,
        input  iDATA_EXCEPT_FRACT_A0,
        input  iDATA_EXCEPT_FRACT_B0,
        output oDATA_VALID,
        input  iDATA_BUSY,
        output oDATA_RESULT,
        output oDATA_OVERFLOW,
        output oDATA_UNDERFLOW,
        output oDATA_INVALID,
        input  iFLAG_CLEAR,
        output oFLAG_STICKY
    );

    modport master (
        output iDATA_VALID,
        input  oDATA_BUSY,
        output iDATA_SIGN,
        output iDATA_EXP,
        output iDATA_FRACT,
        output iDATA_EXCEPT_EXP_A0,
        output iDATA_EXCEPT_EXP_B0,
        output iDATA_EXCEPT_EXP_A1,
        output iDATA_EXCEPT_EXP_B1,
        output iDATA_EXCEPT_FRACT_A0,
        output iDATA_EXCEPT_FRACT_B0,
        input  oDATA_VALID,
        output iDATA_BUSY,
        input  oDATA_RESULT,
        input  oDATA_OVERFLOW,
        input  oDATA_UNDERFLOW,
        input  oDATA_INVALID,
        output iFLAG_CLEAR,
        input  oFLAG_STICKY
    );
endinterface

// File: rtl/fmul_72bit_result_pack.sv
// Final stage of the 72-bit FP multiplier: resolves special cases, packs
// {sign, exp[10:0], fract[59:0]} and buffers results in a 2-entry FIFO.
// Optional sticky exception flags are built when FMUL72_PACK_STICKY_FLAGS_EN
// is defined; otherwise oFLAG_STICKY is tied low and iFLAG_CLEAR is ignored.
module fmul_72bit_result_pack (
    input logic                      iCLOCK,
    input logic                      inRESET,
    input logic                      iRESET_SYNC,
    fmul_72bit_result_pack_if.slave  bus
);

    localparam logic [71:0] CanonNan = 72'h7FF800000000000000;

    // Entry layout: {invalid, overflow, underflow, result[71:0]}
    localparam int unsigned EntryW = 75;

    // ------------------------------------------------------------------
    // Operand classification (denormals count as zero)
    // ------------------------------------------------------------------
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic is_invalid, is_inf, is_zero;
    logic exp_ovf, exp_unf;
    logic signed [12:0] exp_s;

    assign zero_a = bus.iDATA_EXCEPT_EXP_A0;
    assign zero_b = bus.iDATA_EXCEPT_EXP_B0;
    assign inf_a  = bus.iDATA_EXCEPT_EXP_A1 & bus.iDATA_EXCEPT_FRACT_A0;
    assign inf_b  = bus.iDATA_EXCEPT_EXP_B1 & bus.iDATA_EXCEPT_FRACT_B0;
    assign nan_a  = bus.iDATA_EXCEPT_EXP_A1 & ~bus.iDATA_EXCEPT_FRACT_A0;
    assign nan_b  = bus.iDATA_EXCEPT_EXP_B1 & ~bus.iDATA_EXCEPT_FRACT_B0;

    assign is_invalid = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
    assign is_inf     = inf_a | inf_b;
    assign is_zero    = zero_a | zero_b;

    assign exp_s   = $signed(bus.iDATA_EXP);
    assign exp_ovf = (exp_s >= 13'sd2047);
    assign exp_unf = (exp_s <= 13'sd0);

    // Hidden bit is implied by the packed format and never stored
    logic unused_hidden_bit;
    assign unused_hidden_bit = bus.iDATA_FRACT[60];

    // ------------------------------------------------------------------
    // Special-case resolution and packing
    // ------------------------------------------------------------------
    logic [71:0] pack_result;
    logic        pack_invalid;
    logic        pack_overflow;
    logic        pack_underflow;

    // Priority-ordered special-case select for the packed word
    always_comb begin
        pack_result    = {bus.iDATA_SIGN, bus.iDATA_EXP[10:0], bus.iDATA_FRACT[59:0]};
        pack_invalid   = 1'b0;
        pack_overflow  = 1'b0;
        pack_underflow = 1'b0;
        if (is_invalid) begin
            pack_result  = CanonNan;
            pack_invalid = 1'b1;
        end else if (is_inf) begin
            pack_result = {bus.iDATA_SIGN, 11'h7FF, 60'h0};
        end else if (is_zero) begin
            pack_result = {bus.iDATA_SIGN, 71'h0};
        end else if (exp_ovf) begin
            pack_result   = {bus.iDATA_SIGN, 11'h7FF, 60'h0};
            pack_overflow = 1'b1;
        end else if (exp_unf) begin
            pack_result    = {bus.iDATA_SIGN, 71'h0};
            pack_underflow = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    logic [EntryW-1:0] entry0_q, entry0_d;
    logic [EntryW-1:0] entry1_q, entry1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] head_entry;
    logic              fifo_full;
    logic              fifo_nempty;
    logic              push;
    logic              pop;

    assign wr_entry    = {pack_invalid, pack_overflow, pack_underflow, pack_result};
    assign fifo_full   = (count_q == 2'd2);
    assign fifo_nempty = (count_q != 2'd0);
    // Busy depends on the count register only, so consumer stall never
    // propagates combinationally upstream.
    assign push        = bus.iDATA_VALID & ~fifo_full;
    assign pop         = fifo_nempty & ~bus.iDATA_BUSY;

    // FIFO next-state: sync clear first, then write/read pointer and count
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iRESET_SYNC) begin
            entry0_d = '0;
            entry1_d = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    entry1_d = wr_entry;
                end else begin
                    entry0_d = wr_entry;
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry          = rd_ptr_q ? entry1_q : entry0_q;
    assign bus.oDATA_VALID     = fifo_nempty;
    assign bus.oDATA_BUSY      = fifo_full;
    assign bus.oDATA_RESULT    = head_entry[71:0];
    assign bus.oDATA_UNDERFLOW = head_entry[72];
    assign bus.oDATA_OVERFLOW  = head_entry[73];
    assign bus.oDATA_INVALID   = head_entry[74];

    // ------------------------------------------------------------------
    // Sticky exception flags {invalid, overflow, underflow}
    // ------------------------------------------------------------------
`ifdef FMUL72_PACK_STICKY_FLAGS_EN
    logic [2:0] sticky_q, sticky_d;

    // Clear first so a push in the same cycle still sets its bit
    always_comb begin
        sticky_d = sticky_q;
        if (iRESET_SYNC) begin
            sticky_d = 3'b000;
        end else begin
            if (bus.iFLAG_CLEAR) begin
                sticky_d = 3'b000;
            end
            if (push) begin
                sticky_d = sticky_d | {pack_invalid, pack_overflow, pack_underflow};
            end
        end
    end

    // Sticky flag register
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.oFLAG_STICKY = sticky_q;
`else
    logic unused_flag_clear;
    assign unused_flag_clear = bus.iFLAG_CLEAR;
    assign bus.oFLAG_STICKY  = 3'b000;
`endif

endmodule

// File: tb/tb_fmul_72bit_result_pack.sv
// Directed, table-driven bench for fmul_72bit_result_pack.
module tb_fmul_72bit_result_pack;

    logic clk;
    logic rst_n;
    logic rst_sync;

    fmul_72bit_result_pack_if bus ();

    fmul_72bit_result_pack dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (rst_sync),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FMUL72_PACK_STICKY_FLAGS_EN
    localparam bit StickyEn = 1'b1;
`else
    localparam bit StickyEn = 1'b0;
`endif

    // flags = {a0, b0, a1, b1, fa0, fb0}; st = {invalid, overflow, underflow}
    typedef struct {
        logic        sign;
        logic [12:0] exp;
        logic [60:0] fract;
        logic [5:0]  flags;
        logic [71:0] res;
        logic [2:0]  st;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int exp_q [$];
    logic [2:0] exp_sticky;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(input int idx);
        bus.iDATA_SIGN            = vecs[idx].sign;
        bus.iDATA_EXP             = vecs[idx].exp;
        bus.iDATA_FRACT           = vecs[idx].fract;
        bus.iDATA_EXCEPT_EXP_A0   = vecs[idx].flags[5];
        bus.iDATA_EXCEPT_EXP_B0   = vecs[idx].flags[4];
        bus.iDATA_EXCEPT_EXP_A1   = vecs[idx].flags[3];
        bus.iDATA_EXCEPT_EXP_B1   = vecs[idx].flags[2];
        bus.iDATA_EXCEPT_FRACT_A0 = vecs[idx].flags[1];
        bus.iDATA_EXCEPT_FRACT_B0 = vecs[idx].flags[0];
    endtask

    // One cycle with a consumer/upstream scoreboard; called at a negedge.
    task automatic cyc(input logic iv, input int idx, input logic ib);
        int e;
        bus.iDATA_VALID = iv;
        if (iv) drive(idx);
        bus.iDATA_BUSY = ib;
        if (bus.oDATA_VALID && !ib) begin
            pops++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_pop: got result %h want no data", bus.oDATA_RESULT);
            end else begin
                e = exp_q.pop_front();
                if (bus.oDATA_RESULT !== vecs[e].res ||
                    {bus.oDATA_INVALID, bus.oDATA_OVERFLOW, bus.oDATA_UNDERFLOW} !== vecs[e].st) begin
                    bad++;
                    $display("FAIL fifo_head: got %h/%b want %h/%b", bus.oDATA_RESULT,
                             {bus.oDATA_INVALID, bus.oDATA_OVERFLOW, bus.oDATA_UNDERFLOW},
                             vecs[e].res, vecs[e].st);
                end
            end
        end
        if (iv && !bus.oDATA_BUSY) exp_q.push_back(idx);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 13'h03FF, 61'h1000000000000000, 6'b000011, 72'h3FF000000000000000, 3'b000};
        vecs[1]  = '{1'b0, 13'h03FF, 61'h1000000000000000, 6'b011010, 72'h7FF800000000000000, 3'b100};
        vecs[2]  = '{1'b1, 13'h0800, 61'h1000000000000000, 6'b000011, 72'hFFF000000000000000, 3'b010};
        vecs[3]  = '{1'b1, 13'h1FFE, 61'h1000000000000000, 6'b000011, 72'h800000000000000000, 3'b001};
        vecs[4]  = '{1'b0, 13'h0000, 61'h1000000000000000, 6'b000011, 72'h000000000000000000, 3'b001};
        vecs[5]  = '{1'b0, 13'h07FF, 61'h1000000000000000, 6'b000011, 72'h7FF000000000000000, 3'b010};
        vecs[6]  = '{1'b0, 13'h07FE, 61'h1123456789ABCDEF, 6'b000000, 72'h7FE123456789ABCDEF, 3'b000};
        vecs[7]  = '{1'b1, 13'h0001, 61'h1FFFFFFFFFFFFFFF, 6'b000000, 72'h801FFFFFFFFFFFFFFF, 3'b000};
        vecs[8]  = '{1'b1, 13'h03FF, 61'h1000000000000000, 6'b001001, 72'h7FF800000000000000, 3'b100};
        vecs[9]  = '{1'b0, 13'h03FF, 61'h1000000000000000, 6'b100110, 72'h7FF800000000000000, 3'b100};
        vecs[10] = '{1'b1, 13'h0900, 61'h1000000000000000, 6'b001011, 72'hFFF000000000000000, 3'b000};
        vecs[11] = '{1'b1, 13'h0800, 61'h1000000000000000, 6'b010011, 72'h800000000000000000, 3'b000};
        vecs[12] = '{1'b0, 13'h03FF, 61'h1000000000000000, 6'b100111, 72'h7FF800000000000000, 3'b100};
        vecs[13] = '{1'b0, 13'h03FF, 61'h1000000000000000, 6'b001111, 72'h7FF000000000000000, 3'b000};
        vecs[14] = '{1'b1, 13'h1000, 61'h1000000000000000, 6'b000011, 72'h800000000000000000, 3'b001};
        vecs[15] = '{1'b0, 13'h03FF, 61'h1000000000000001, 6'b000011, 72'h3FF000000000000001, 3'b000};

        rst_n           = 1'b0;
        rst_sync        = 1'b0;
        bus.iDATA_VALID = 1'b0;
        bus.iDATA_BUSY  = 1'b0;
        bus.iFLAG_CLEAR = 1'b0;
        drive(0);
        exp_sticky = 3'b000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", bus.oDATA_VALID, 1'b0);
        check("rst_busy", bus.oDATA_BUSY, 1'b0);
        check("rst_result", bus.oDATA_RESULT, 72'h0);
        check("rst_status", {bus.oDATA_INVALID, bus.oDATA_OVERFLOW, bus.oDATA_UNDERFLOW}, 3'b000);
        check("rst_sticky", bus.oFLAG_STICKY, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-shot vectors: push, see it 1 cycle later, then pop
        for (int i = 0; i < NV; i++) begin
            drive(i);
            bus.iDATA_VALID = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.iDATA_VALID = 1'b0;
            exp_sticky = exp_sticky | vecs[i].st;
            check($sformatf("v%0d_valid", i), bus.oDATA_VALID, 1'b1);
            check($sformatf("v%0d_result", i), bus.oDATA_RESULT, vecs[i].res);
            check($sformatf("v%0d_status", i),
                  {bus.oDATA_INVALID, bus.oDATA_OVERFLOW, bus.oDATA_UNDERFLOW}, vecs[i].st);
            check($sformatf("v%0d_sticky", i), bus.oFLAG_STICKY, StickyEn ? exp_sticky : 3'b000);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_empty", i), bus.oDATA_VALID, 1'b0);
        end

        // Flag clear
        bus.iFLAG_CLEAR = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.iFLAG_CLEAR = 1'b0;
        check("sticky_cleared", bus.oFLAG_STICKY, 3'b000);

`ifdef FMUL72_PACK_STICKY_FLAGS_EN
        // inf x 0 alone sets only invalid, held until clear
        cyc(1'b1, 1, 1'b0);
        cyc(1'b0, 0, 1'b0);
        check("sticky_inv_only", bus.oFLAG_STICKY, 3'b100);
        cyc(1'b0, 0, 1'b0);
        check("sticky_inv_hold", bus.oFLAG_STICKY, 3'b100);
        // Clear concurrent with an overflow push keeps the overflow bit
        bus.iFLAG_CLEAR = 1'b1;
        cyc(1'b1, 2, 1'b0);
        bus.iFLAG_CLEAR = 1'b0;
        check("sticky_clear_vs_push", bus.oFLAG_STICKY, 3'b010);
        cyc(1'b0, 0, 1'b0);
        bus.iFLAG_CLEAR = 1'b1;
        cyc(1'b0, 0, 1'b0);
        bus.iFLAG_CLEAR = 1'b0;
        check("sticky_clear2", bus.oFLAG_STICKY, 3'b000);
`endif

        // Back-pressure: 3 inputs with consumer stalled
        pops = 0;
        cyc(1'b1, 0, 1'b1);
        check("bp_busy_after1", bus.oDATA_BUSY, 1'b0);
        cyc(1'b1, 6, 1'b1);
        check("bp_busy_after2", bus.oDATA_BUSY, 1'b1);
        cyc(1'b1, 7, 1'b1);
        check("bp_busy_held", bus.oDATA_BUSY, 1'b1);
        check("bp_head_held", bus.oDATA_RESULT, vecs[0].res);
        cyc(1'b1, 7, 1'b0);
        check("bp_busy_fall", bus.oDATA_BUSY, 1'b0);
        cyc(1'b1, 7, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        check("bp_pops", pops, 3);
        check("bp_empty", bus.oDATA_VALID, 1'b0);

        // Streaming: 10 back-to-back results
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) check($sformatf("st%0d_valid", k), bus.oDATA_VALID, 1'b1);
            check($sformatf("st%0d_busy", k), bus.oDATA_BUSY, 1'b0);
            cyc(1'b1, k, 1'b0);
        end
        for (int k = 0; k < 4 && bus.oDATA_VALID; k++) cyc(1'b0, 0, 1'b0);
        check("st_pops", pops, 10);

        // Sync clear while full, with a push attempt pending
        cyc(1'b1, 1, 1'b1);
        cyc(1'b1, 2, 1'b1);
        check("sr_full", bus.oDATA_BUSY, 1'b1);
        rst_sync        = 1'b1;
        bus.iDATA_VALID = 1'b1;
        bus.iFLAG_CLEAR = 1'b0;
        drive(0);
        bus.iDATA_BUSY  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_sync        = 1'b0;
        bus.iDATA_VALID = 1'b0;
        exp_q.delete();
        check("sr_valid", bus.oDATA_VALID, 1'b0);
        check("sr_busy", bus.oDATA_BUSY, 1'b0);
        check("sr_sticky", bus.oFLAG_STICKY, 3'b000);
        check("sr_result", bus.oDATA_RESULT, 72'h0);
        pops = 0;
        cyc(1'b1, 6, 1'b0);
        check("sr_push_valid", bus.oDATA_VALID, 1'b1);
        cyc(1'b0, 0, 1'b0);
        check("sr_push_pops", pops, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmul_72bit_result_pack.md
# fmul_72bit_result_pack

Final stage of the 72-bit floating-point multiplier pipeline, directly downstream of the normalize/round stage. It takes the rounded sign, internal 13-bit exponent, 61-bit significand and per-operand exception flags, and resolves special cases (NaN, infinity, zero, overflow, underflow). It packs the 72-bit result word: sign[71], exp[70:60], fract[59:0]. A 2-entry output FIFO decouples the pipeline busy chain from the consumer.

## Interface
- No parameters.
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear; same effect as reset
- iDATA_VALID  in  1  upstream result valid
- oDATA_BUSY  out  1  back-pressure to upstream; asserted iff FIFO holds 2 entries
- iDATA_SIGN  in  1  product sign
- iDATA_EXP  in  13  biased exponent, two's complement (bias 1023)
- iDATA_FRACT  in  61  significand; bit 60 is the hidden bit
- iDATA_EXCEPT_EXP_A0 / _B0  in  1  operand A/B exponent all-zero
- iDATA_EXCEPT_EXP_A1 / _B1  in  1  operand A/B exponent all-one
- iDATA_EXCEPT_FRACT_A0 / _B0  in  1  operand A/B fraction zero
- oDATA_VALID  out  1  FIFO head valid
- iDATA_BUSY  in  1  consumer stall
- oDATA_RESULT  out  72  packed result at FIFO head
- oDATA_OVERFLOW / oDATA_UNDERFLOW / oDATA_INVALID  out  1  per-result status at FIFO head
- iFLAG_CLEAR  in  1  clears the sticky flags
- oFLAG_STICKY  out  3  {invalid, overflow, underflow}, accumulated

## Operation
- Operand classes, with X = A or B:
  - zero(X) = EXP_X0; denormals are treated as zero.
  - inf(X) = EXP_X1 & FRACT_X0.
  - nan(X) = EXP_X1 & !FRACT_X0.
- Classification is combinational. Priority order:
  1. Invalid: nan(A) | nan(B) | (inf(A) & zero(B)) | (zero(A) & inf(B)). Result is canonical NaN 72'h7FF800000000000000 (sign 0). INVALID=1.
  2. Infinity: inf(A) | inf(B). Result is {sign, 11'h7FF, 60'h0}.
  3. Zero: zero(A) | zero(B). Result is {sign, 71'h0}.
  4. Overflow: signed iDATA_EXP >= 2047. Result is {sign, 11'h7FF, 60'h0}. OVERFLOW=1.
  5. Underflow: signed iDATA_EXP <= 0. Result is {sign, 71'h0} (flush). UNDERFLOW=1.
  6. Normal: {sign, iDATA_EXP[10:0], iDATA_FRACT[59:0]}.
- Push: iDATA_VALID & !oDATA_BUSY writes {result, 3 status bits} to the FIFO tail.
- Pop: oDATA_VALID & !iDATA_BUSY advances the head.
- FIFO: 2 entries, 1-bit write and read pointers, and a 2-bit count.
  - Push and pop in the same cycle: count unchanged.
  - Push and pop cannot both occur at count 2, because oDATA_BUSY is high.
  - Pointers wrap 1 -> 0.
- oDATA_BUSY = (count == 2). It is combinational from the count register only, so there is no path from iDATA_BUSY to oDATA_BUSY. Upstream holds its registered output while busy, so no data is lost or duplicated.
- iDATA_VALID low with busy low: nothing is written.
- Reset or iRESET_SYNC in mid-operation:
  - Count, pointers and all entries go to 0.
  - Pending data is discarded.
  - oFLAG_STICKY goes to 0.
  - iRESET_SYNC has priority over push, pop and iFLAG_CLEAR.

## Timing
- Latency is 1 cycle. An input accepted at edge N is visible on oDATA_* after edge N when the FIFO was empty, or after the older entry pops.
- Sustains 1 result per cycle when iDATA_BUSY is low.
- Reset values:
  - oDATA_VALID=0, oDATA_BUSY=0.
  - oDATA_RESULT=72'h0.
  - oDATA_OVERFLOW, oDATA_UNDERFLOW, oDATA_INVALID = 0.
  - oFLAG_STICKY=3'b000.
- When empty, oDATA_RESULT and the status outputs show the stale head entry (0 after reset). Consumers ignore them.
- oDATA_BUSY rises the cycle after the push that fills the FIFO. It falls the cycle after the pop from full.

## Configuration
- FMUL72_PACK_STICKY_FLAGS_EN defined:
  - oFLAG_STICKY bits are set at each push whose status bit is 1.
  - iFLAG_CLEAR zeroes them at the next edge.
  - A push event in the same cycle as iFLAG_CLEAR leaves that bit set.
- Undefined:
  - oFLAG_STICKY is tied to 3'b000 and iFLAG_CLEAR is ignored.
  - No sticky registers are built.

## Test plan
- 1.0×1.0: exp 13'h3FF, fract bit 60 set, no flags -> oDATA_RESULT 72'h3FF000000000000000, all status bits 0, valid 1 cycle after push.
- EXP_A1=1, FRACT_A0=1, EXP_B0=1 (inf×0) -> 72'h7FF800000000000000 with INVALID=1. With the macro defined, oFLAG_STICKY=3'b100 until iFLAG_CLEAR.
- Exponent 13'h0800 with sign 1 -> 72'hFFF000000000000000, OVERFLOW=1. Exponent 13'h1FFE (-2) -> 72'h800000000000000000, UNDERFLOW=1.
- Hold iDATA_BUSY=1 and stream 3 valid inputs -> oDATA_BUSY high after the 2nd push and the 3rd input held upstream. On release, the 3 results emerge in order with no drop or duplicate.
- Continuous push with iDATA_BUSY=0 for 10 cycles -> 10 results in consecutive cycles, oDATA_BUSY never high.
- FIFO at count 2, pulse iRESET_SYNC -> next cycle oDATA_VALID=0, oDATA_BUSY=0, oFLAG_STICKY=0. A subsequent push works normally.
